rf_wb_arbiter: RTL and testbench

- Writeback stage that feeds the register file's single write port (io_rf_wa / io_rf_wen / io_rf_wd).
- Two producers share that port:
  - the single-cycle ALU result, which has priority;
  - load responses from the memory unit, which arrive unpredictably.
- Load responses are sign- or zero-extended and lane-aligned, then queued in a small FIFO. The FIFO drains on cycles where the ALU is idle or where a starvation guard stalls the ALU.

---
 rtl/rf_wb_arbiter.sv | 83 ++++++++
 tb/tb_rf_wb_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: writeback arbiter sharing one register-file write port between the ALU and queued load responses
// Ports: clk, reset (async, active-low); io_alu_* ALU result in, io_alu_stall out;
// io_mem_* load response in with io_mem_ready out; io_rf_* registered write port; io_busy.
module rf_wb_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_alu_valid,
  input  logic [4:0]  io_alu_wa,
  input  logic [31:0] io_alu_wd,
  output logic        io_alu_stall,
  input  logic        io_mem_valid,
  output logic        io_mem_ready,
  input  logic [4:0]  io_mem_wa,
  input  logic [31:0] io_mem_rdata,
  input  logic [2:0]  io_mem_funct3,
  input  logic [1:0]  io_mem_addr_lo,
  output logic [4:0]  io_rf_wa,
  output logic        io_rf_wen,
  output logic [31:0] io_rf_wd,
  output logic        io_busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [4:0]    q_wa [DEPTH];
  logic [31:0]   q_wd [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic [SW-1:0] starve, starve_inc;
  logic [31:0]   shifted, mem_fmt;
  logic [15:0]   half;
  logic [7:0]    byte_sel;
  logic          empty, push, keep, alu_win, pop, bypass, store, starving, hit;
  always_comb begin
    shifted  = io_mem_rdata >> {io_mem_addr_lo, 3'b000};
    byte_sel = shifted[7:0];
    half     = io_mem_addr_lo[1] ? io_mem_rdata[31:16] : io_mem_rdata[15:0];
    mem_fmt  = io_mem_funct3 == 3'd0 ? {{24{byte_sel[7]}}, byte_sel} :
               io_mem_funct3 == 3'd4 ? {24'b0, byte_sel} :
               io_mem_funct3 == 3'd1 ? {{16{half[15]}}, half} :
               io_mem_funct3 == 3'd5 ? {16'b0, half} : io_mem_rdata;
  end
  assign empty        = count == '0;
  assign io_mem_ready = count != (AW+1)'(DEPTH);
  assign io_busy      = !empty || io_rf_wen;
  assign push         = io_mem_valid && io_mem_ready;
  assign keep         = push && io_mem_wa != 5'd0;
  assign alu_win      = io_alu_valid && !io_alu_stall && io_alu_wa != 5'd0;
  assign pop          = !alu_win && !empty;
  // an empty FIFO lets a fresh load skip storage and write straight through
  assign bypass       = !alu_win && empty && keep;
  assign store        = keep && !bypass;
  assign starving     = alu_win && !empty;
  assign starve_inc   = starve + SW'(1);
  assign hit          = starving && starve_inc == SW'(STARVE_LIMIT);
  always_ff @(posedge clk) if (store) begin
    q_wa[wr_ptr] <= io_mem_wa;
    q_wd[wr_ptr] <= mem_fmt;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      starve       <= '0;
      io_alu_stall <= 1'b0;
      io_rf_wen    <= 1'b0;
      io_rf_wa     <= 5'd0;
      io_rf_wd     <= 32'd0;
    end else begin
      rd_ptr       <= rd_ptr + AW'(pop);
      wr_ptr       <= wr_ptr + AW'(store);
      count        <= count + (AW+1)'(store) - (AW+1)'(pop);
      starve       <= starving && !hit ? starve_inc : '0;
      io_alu_stall <= hit;
      io_rf_wen    <= alu_win || pop || bypass;
      io_rf_wa     <= alu_win ? io_alu_wa : pop ? q_wa[rd_ptr] : bypass ? io_mem_wa : 5'd0;
      io_rf_wd     <= alu_win ? io_alu_wd : pop ? q_wd[rd_ptr] : bypass ? mem_fmt : 32'd0;
    end
  end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: randomized and directed bench for rf_wb_arbiter against a queue-based reference model
module tb_rf_wb_arbiter;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;
  logic clk = 0, reset = 0;
  logic io_alu_valid = 0, io_mem_valid = 0;
  logic [4:0] io_alu_wa = 0, io_mem_wa = 0;
  logic [31:0] io_alu_wd = 0, io_mem_rdata = 0;
  logic [2:0] io_mem_funct3 = 0;
  logic [1:0] io_mem_addr_lo = 0;
  logic io_alu_stall, io_mem_ready, io_rf_wen, io_busy;
  logic [4:0] io_rf_wa;
  logic [31:0] io_rf_wd;
  int checks = 0, passes = 0;
  logic [36:0] q_m[$];
  int sc_m = 0;
  bit stall_m = 0, ew = 0, acc = 0;
  logic [4:0] ewa = 0;
  logic [31:0] ewd = 0;

  rf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .io_alu_valid(io_alu_valid), .io_alu_wa(io_alu_wa), .io_alu_wd(io_alu_wd), .io_alu_stall(io_alu_stall),
    .io_mem_valid(io_mem_valid), .io_mem_ready(io_mem_ready), .io_mem_wa(io_mem_wa), .io_mem_rdata(io_mem_rdata),
    .io_mem_funct3(io_mem_funct3), .io_mem_addr_lo(io_mem_addr_lo),
    .io_rf_wa(io_rf_wa), .io_rf_wen(io_rf_wen), .io_rf_wd(io_rf_wd), .io_busy(io_busy));

  always #5 clk = ~clk;

  always @(posedge clk) if (reset) assert (!(io_alu_stall && io_alu_valid)) else $error("protocol violation: alu_valid during stall");

  function automatic logic [31:0] fmt(logic [31:0] rd, logic [2:0] f3, logic [1:0] alo);
    int sh = int'(alo) * 8;
    logic [31:0] b = (rd >> sh) & 32'hFF;
    logic [31:0] h = alo[1] ? rd >> 16 : rd & 32'hFFFF;
    case (f3)
      3'd0: return b >= 128 ? b + 32'hFFFFFF00 : b;
      3'd4: return b;
      3'd1: return h >= 32768 ? h + 32'hFFFF0000 : h;
      3'd5: return h;
      default: return rd;
    endcase
  endfunction

  task automatic model_reset();
    q_m.delete();
    sc_m = 0; stall_m = 0; ew = 0; ewa = 0; ewd = 0;
  endtask

  // drives one cycle at the negedge, advances the model, returns at the next negedge
  task automatic step(input bit av, input logic [4:0] awa, input logic [31:0] awd, input bit mv,
                      input logic [4:0] mwa, input logic [31:0] mrd, input logic [2:0] f3, input logic [1:0] alo);
    int had = q_m.size();
    bit rdy = had < DEPTH;
    bit aw = av && !stall_m && awa != 0;
    bit pk = mv && rdy && mwa != 0;
    logic [36:0] e;
    io_alu_valid = av; io_alu_wa = awa; io_alu_wd = awd;
    io_mem_valid = mv; io_mem_wa = mwa; io_mem_rdata = mrd; io_mem_funct3 = f3; io_mem_addr_lo = alo;
    acc = mv && rdy;
    ew = 0;
    if (aw) begin ew = 1; ewa = awa; ewd = awd; end
    else if (had > 0) begin e = q_m.pop_front(); ew = 1; ewa = e[36:32]; ewd = e[31:0]; end
    else if (pk) begin ew = 1; ewa = mwa; ewd = fmt(mrd, f3, alo); pk = 0; end
    if (pk) q_m.push_back({mwa, fmt(mrd, f3, alo)});
    sc_m = (aw && had > 0) ? sc_m + 1 : 0;
    stall_m = sc_m == LIMIT;
    if (stall_m) sc_m = 0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({io_rf_wen, io_rf_wa, io_rf_wd, io_alu_stall, io_mem_ready, io_busy} !== {1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0})
      $display("FAIL reset_state wen=%b wa=%0d wd=%h stall=%b ready=%b busy=%b", io_rf_wen, io_rf_wa, io_rf_wd, io_alu_stall, io_mem_ready, io_busy);
    else passes++;
    reset = 1;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      idle();
      checks++;
      if (io_rf_wen !== 0 || io_mem_ready !== 1 || io_busy !== 0)
        $display("FAIL reset_idle cyc=%0d wen=%b ready=%b busy=%b want 0/1/0", i, io_rf_wen, io_mem_ready, io_busy);
      else passes++;
    end
  endtask

  task automatic test_alu();
    step(1, 5, 32'h1234, 0, 0, 0, 0, 0);
    checks++;
    if (io_rf_wen !== 1 || io_rf_wa !== 5 || io_rf_wd !== 32'h1234)
      $display("FAIL alu_write wen=%b wa=%0d wd=%h want 1/5/1234", io_rf_wen, io_rf_wa, io_rf_wd);
    else passes++;
    idle();
    checks++;
    if (io_rf_wen !== 0) $display("FAIL alu_one_cycle wen=%b want 0", io_rf_wen);
    else passes++;
  endtask

  task automatic test_load_format();
    logic [2:0] f3s[4] = '{3'd0, 3'd4, 3'd1, 3'd5};
    logic [1:0] alos[4] = '{2'd2, 2'd3, 2'd2, 2'd0};
    logic [31:0] exps[4] = '{32'hFFFFFFFF, 32'h00000080, 32'hFFFF80FF, 32'h00007F01};
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, 7, 32'h80FF7F01, f3s[i], alos[i]);
      checks++;
      if (io_rf_wen !== 1 || io_rf_wa !== 7 || io_rf_wd !== exps[i] || io_mem_ready !== 1)
        $display("FAIL load_fmt f3=%0d alo=%0d wen=%b wa=%0d wd=%h ready=%b want wd=%h", f3s[i], alos[i], io_rf_wen, io_rf_wa, io_rf_wd, io_mem_ready, exps[i]);
      else passes++;
    end
    for (int i = 0; i < 24; i++) begin
      step(0, 0, 0, 1, 5'($urandom_range(1, 31)), $urandom, 3'($urandom), 2'($urandom));
      checks++;
      if (io_rf_wen !== ew || (ew && (io_rf_wa !== ewa || io_rf_wd !== ewd)) || io_mem_ready !== 1)
        $display("FAIL load_fmt_rand i=%0d wen=%b wa=%0d wd=%h want %b/%0d/%h", i, io_rf_wen, io_rf_wa, io_rf_wd, ew, ewa, ewd);
      else passes++;
    end
    idle();
  endtask

  task automatic test_starvation();
    int accepted = 0, first_stall = -1, acc_at_low = -1, first_load = -1, n = 0;
    logic [4:0] order[$];
    for (int cyc = 0; cyc < 100 && !(accepted == 5 && q_m.size() == 0 && cyc > 0 && !ew); cyc++) begin
      step(!stall_m, 5'(1 + cyc % 15), $urandom, accepted < 5, 5'(16 + accepted), $urandom, 3'd2, 2'd0);
      if (acc) accepted++;
      checks++;
      if (io_rf_wen !== ew || (ew && (io_rf_wa !== ewa || io_rf_wd !== ewd)) || io_alu_stall !== stall_m ||
          io_mem_ready !== (q_m.size() < DEPTH) || io_busy !== (q_m.size() != 0 || ew))
        $display("FAIL starve_model cyc=%0d wen=%b wa=%0d wd=%h stall=%b ready=%b want %b/%0d/%h/%b/%b",
                 cyc + 1, io_rf_wen, io_rf_wa, io_rf_wd, io_alu_stall, io_mem_ready, ew, ewa, ewd, stall_m, q_m.size() < DEPTH);
      else passes++;
      if (io_alu_stall && first_stall < 0) first_stall = cyc + 1;
      if (!io_mem_ready && acc_at_low < 0) acc_at_low = accepted;
      if (io_rf_wen && io_rf_wa >= 16) begin
        order.push_back(io_rf_wa);
        if (first_load < 0) first_load = cyc + 1;
      end
    end
    checks++;
    if (acc_at_low !== 4) $display("FAIL starve_ready_low accepted=%0d want 4", acc_at_low);
    else passes++;
    checks++;
    if (first_stall !== 9) $display("FAIL starve_stall_cycle got=%0d want 9", first_stall);
    else passes++;
    checks++;
    if (first_load !== 10) $display("FAIL starve_first_load got=%0d want 10", first_load);
    else passes++;
    checks++;
    n = order.size();
    if (n != 5 || order[0] !== 16 || order[1] !== 17 || order[2] !== 18 || order[3] !== 19 || order[4] !== 20)
      $display("FAIL starve_order count=%0d want 5 in order 16..20", n);
    else passes++;
  endtask

  task automatic test_wa0();
    step(1, 3, 32'hAAAA, 1, 9, 32'hCAFE0001, 3'd2, 2'd0);
    checks++;
    if (io_rf_wa !== 3 || io_busy !== 1 || q_m.size() != 1)
      $display("FAIL wa0_queue wa=%0d busy=%b want 3/1", io_rf_wa, io_busy);
    else passes++;
    step(1, 0, 32'h5555, 0, 0, 0, 0, 0);
    checks++;
    if (io_rf_wen !== 1 || io_rf_wa !== 9 || io_rf_wd !== 32'hCAFE0001)
      $display("FAIL wa0_alu_slot wen=%b wa=%0d wd=%h want 1/9/cafe0001", io_rf_wen, io_rf_wa, io_rf_wd);
    else passes++;
    step(0, 0, 0, 1, 0, 32'h12345678, 3'd2, 2'd0);
    checks++;
    if (io_rf_wen !== 0 || io_busy !== 0 || io_mem_ready !== 1 || acc !== 1)
      $display("FAIL wa0_load wen=%b busy=%b ready=%b want 0/0/1", io_rf_wen, io_busy, io_mem_ready);
    else passes++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(!stall_m && $urandom_range(0, 1), ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), $urandom,
           1'($urandom), 5'($urandom), $urandom, 3'($urandom), 2'($urandom));
      checks++;
      if (io_rf_wen !== ew || (ew && (io_rf_wa !== ewa || io_rf_wd !== ewd)) || io_alu_stall !== stall_m ||
          io_mem_ready !== (q_m.size() < DEPTH) || io_busy !== (q_m.size() != 0 || ew))
        $display("FAIL random i=%0d wen=%b wa=%0d wd=%h stall=%b ready=%b busy=%b want %b/%0d/%h/%b/%b",
                 i, io_rf_wen, io_rf_wa, io_rf_wd, io_alu_stall, io_mem_ready, io_busy, ew, ewa, ewd, stall_m, q_m.size() < DEPTH);
      else passes++;
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 20 && (q_m.size() != 0 || stall_m); i++) idle();
    for (int i = 0; i < 3; i++) step(1, 1, 32'h11, 1, 5'(20 + i), $urandom, 3'd2, 2'd0);
    checks++;
    if (q_m.size() != 3 || io_busy !== 1) $display("FAIL mid_fill busy=%b want 1", io_busy);
    else passes++;
    #2 reset = 0;
    #1;
    model_reset();
    checks++;
    if ({io_rf_wen, io_alu_stall, io_mem_ready, io_busy} !== 4'b0010)
      $display("FAIL mid_reset wen=%b stall=%b ready=%b busy=%b want 0/0/1/0", io_rf_wen, io_alu_stall, io_mem_ready, io_busy);
    else passes++;
    @(negedge clk);
    reset = 1;
    for (int i = 0; i < 5; i++) begin
      idle();
      checks++;
      if (io_rf_wen !== 0 || io_busy !== 0 || io_mem_ready !== 1)
        $display("FAIL mid_after cyc=%0d wen=%b busy=%b ready=%b want 0/0/1", i, io_rf_wen, io_busy, io_mem_ready);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_format();
    test_starvation();
    test_wa0();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
